// File: rtl/ldpc_pkg.sv
// Shared constants, types and the cyclic-shift address mapping for the RAM port blocks.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// The writer and the reader both call shift_addr() so that both ends of a RAM
// bank always agree on where logical entry i physically lives.
package ldpc_pkg;

    localparam int Z       = 64;  // expansion factor, entries per block
    localparam int ADDR_W  = 8;   // RAM address width
    localparam int DATA_W  = 4;   // RAM data width
    localparam int SHIFT_W = 7;   // cyclic shift width

    // Reader control states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_t;

    // One buffered entry: RAM data plus the logical index it belongs to.
    typedef struct packed {
        logic              last;
        logic [ADDR_W-1:0] idx;
        logic [DATA_W-1:0] dat;
    } rd_entry_t;

    localparam int ENTRY_W = $bits(rd_entry_t);

    // Z widened by one bit so idx + (Z - shift) cannot wrap.
    localparam logic [ADDR_W:0] Z_EXT = (ADDR_W+1)'(Z);

    // Physical address of logical entry idx in a bank rotated by shift.
    // shift must already be reduced to 0..Z-1.
    function automatic logic [ADDR_W-1:0] shift_addr(
        input logic [ADDR_W-1:0]  idx,
        input logic [SHIFT_W-1:0] shift
    );
        logic [ADDR_W:0] sum;
        sum = {1'b0, idx} + Z_EXT - {{(ADDR_W+1-SHIFT_W){1'b0}}, shift};
        if (sum < Z_EXT) begin
            return sum[ADDR_W-1:0];
        end
        return idx - ADDR_W'(shift);
    endfunction

endpackage

// File: rtl/ram_port_1_reader_if.sv
// Bundle of the reader's control, RAM read port and output stream signals.
// Latency: n/a (wiring only).
// Backpressure: out_ready stalls the stream; the reader throttles RAM reads.
//
// Ports (slave = reader side):
//   start/cyclic_shif         block request and its rotation
//   ram_rd_en/addr/data       single read port, data one cycle after enable
//   out_valid/ready/data/idx/last   logical-order entry stream
//   busy/done/shift_err       status
interface ram_port_1_reader_if;
    import ldpc_pkg::*;

    logic               start;
    logic [SHIFT_W-1:0] cyclic_shif;
    logic               ram_rd_en;
    logic [ADDR_W-1:0]  ram_rd_addr;
    logic [DATA_W-1:0]  ram_rd_data;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  out_data;
    logic [ADDR_W-1:0]  out_idx;
    logic               out_last;
    logic               busy;
    logic               done;
    logic               shift_err;

    // Reader side.
    modport slave (
        input  start, cyclic_shif, ram_rd_data, out_ready,
        output ram_rd_en, ram_rd_addr, out_valid, out_data, out_idx, out_last,
               busy, done, shift_err
    );

    // Environment side: controller, RAM and downstream consumer.
    modport master (
        output start, cyclic_shif, ram_rd_data, out_ready,
        input  ram_rd_en, ram_rd_addr, out_valid, out_data, out_idx, out_last,
               busy, done, shift_err
    );

endinterface

// File: rtl/ldpc_skid_fifo2.sv
// Two-entry FIFO absorbing RAM read latency between the read issue logic and the stream.
// Latency: an entry pushed on one edge is at the head on the next cycle.
// Backpressure: head holds while head_rdy_i is low; push and pop may share a cycle.
//
// Ports:
//   clk_i, rst_n_i              clock, async active-low reset
//   push_vld_i, push_dat_i      write side (caller guarantees a free slot)
//   head_vld_o, head_rdy_i      read handshake, head_dat_o is the oldest entry
//   occ_o                       current occupancy 0..2, used for read credits
module ldpc_skid_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         push_vld_i,
    input  logic [W-1:0] push_dat_i,
    output logic         head_vld_o,
    input  logic         head_rdy_i,
    output logic [W-1:0] head_dat_o,
    output logic [1:0]   occ_o
);

    logic [W-1:0] slot_q [2];
    logic         rd_ptr_q, rd_ptr_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         push;
    logic         pop;

    assign head_vld_o = (cnt_q != 2'd0);
    assign head_dat_o = slot_q[rd_ptr_q];
    assign occ_o      = cnt_q;

    assign pop  = head_vld_o & head_rdy_i;
    // A full FIFO only accepts when the head leaves in the same cycle; the
    // upstream credit check keeps this from ever refusing real data.
    assign push = push_vld_i & ((cnt_q != 2'd2) | pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            slot_q[0] <= '0;
            slot_q[1] <= '0;
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            cnt_q     <= 2'd0;
        end else begin
            // When full with a simultaneous pop, wr_ptr equals rd_ptr and the
            // departing head slot is the one overwritten.
            if (push) begin
                slot_q[wr_ptr_q] <= push_dat_i;
            end
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/ram_port_1_reader.sv
// Drains one Z-entry block from a cyclically shifted RAM bank as a logical-order stream.
// Latency: first out_valid two edges after start is taken; done Z+2 edges after start.
// Backpressure: out_ready stalls the stream; reads stop while the 2-entry buffer has no credit.
//
// Ports:
//   sys_clk, sys_rst_n   clock, async active-low reset (mid-block reset drops the block, no done)
//   bus (slave)          start/cyclic_shif in, RAM read port, output stream, busy/done/shift_err
module ram_port_1_reader
    import ldpc_pkg::*;
(
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    ram_port_1_reader_if.slave  bus
);

    localparam logic [SHIFT_W-1:0] Z_SHIFT  = SHIFT_W'(Z);
    localparam logic [ADDR_W-1:0]  LAST_IDX = ADDR_W'(Z - 1);

    rd_state_t          state_q, state_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic [ADDR_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic               rd_vld_q;           // a read was issued last cycle
    logic [ADDR_W-1:0]  rd_idx_q;           // logical index of that read
    logic               done_q, done_d;
    logic               shift_err_q, shift_err_d;

    logic               rd_issue;
    logic               credit_ok;
    logic [2:0]         credit_used;
    logic               head_vld;
    logic               fire;
    logic [1:0]         fifo_occ;
    rd_entry_t          push_ent;
    rd_entry_t          head_ent;

    // ------------------------------------------------------------------
    // Entry buffer. Returning RAM data is tagged with the index that was
    // carried alongside its read.
    // ------------------------------------------------------------------
    assign push_ent.dat  = bus.ram_rd_data;
    assign push_ent.idx  = rd_idx_q;
    assign push_ent.last = (rd_idx_q == LAST_IDX);

    ldpc_skid_fifo2 #(
        .W (ENTRY_W)
    ) u_buf (
        .clk_i      (sys_clk),
        .rst_n_i    (sys_rst_n),
        .push_vld_i (rd_vld_q),
        .push_dat_i (push_ent),
        .head_vld_o (head_vld),
        .head_rdy_i (bus.out_ready),
        .head_dat_o (head_ent),
        .occ_o      (fifo_occ)
    );

    assign fire = head_vld & bus.out_ready;

    // Occupied slots plus the read whose data is on the RAM bus, minus the
    // entry leaving this cycle. Counting the pop lets the pipeline sustain
    // one read per cycle when downstream never stalls.
    assign credit_used = {1'b0, fifo_occ} + {2'b00, rd_vld_q} - {2'b00, fire};
    assign credit_ok   = (credit_used < 3'd2);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        rd_cnt_d    = rd_cnt_q;
        rd_issue    = 1'b0;
        done_d      = 1'b0;
        shift_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.cyclic_shif > Z_SHIFT) begin
                        shift_err_d = 1'b1;
                    end else begin
                        // A full-block rotation is the identity mapping.
                        shift_d  = (bus.cyclic_shif == Z_SHIFT) ? '0 : bus.cyclic_shif;
                        rd_cnt_d = '0;
                        state_d  = ST_READ;
                    end
                end
            end

            ST_READ: begin
                if (credit_ok) begin
                    rd_issue = 1'b1;
                    if (rd_cnt_q == LAST_IDX) begin
                        state_d = ST_DRAIN;
                    end else begin
                        rd_cnt_d = rd_cnt_q + 1'b1;
                    end
                end
            end

            ST_DRAIN: begin
                if (fire && head_ent.last) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            rd_cnt_q    <= '0;
            rd_vld_q    <= 1'b0;
            rd_idx_q    <= '0;
            done_q      <= 1'b0;
            shift_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            rd_cnt_q    <= rd_cnt_d;
            rd_vld_q    <= rd_issue;
            if (rd_issue) begin
                rd_idx_q <= rd_cnt_q;
            end
            done_q      <= done_d;
            shift_err_q <= shift_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.ram_rd_en   = rd_issue;
    // Address bus is parked at 0 between reads.
    assign bus.ram_rd_addr = rd_issue ? shift_addr(rd_cnt_q, shift_q) : '0;

    assign bus.out_valid   = head_vld;
    assign bus.out_data    = head_ent.dat;
    assign bus.out_idx     = head_ent.idx;
    assign bus.out_last    = head_ent.last;

    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.done        = done_q;
    assign bus.shift_err   = shift_err_q;

endmodule

// File: tb/tb_ram_port_1_reader.sv
module tb_ram_port_1_reader;
    import ldpc_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_port_1_reader_if bus();

    ram_port_1_reader dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (bus)
    );

    logic [DATA_W-1:0] mem     [256];
    logic [DATA_W-1:0] logical [Z];

    int total = 0;
    int bad   = 0;

    // Single-port RAM, one cycle read latency; garbage on the bus when idle.
    always @(posedge clk) begin
        bus.ram_rd_data <= bus.ram_rd_en ? mem[bus.ram_rd_addr] : DATA_W'($urandom);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Writer's placement: logical entry i of a block rotated by s.
    function automatic int phys(input int i, input int s);
        return (((i - s) % Z) + Z) % Z;
    endfunction

    task automatic load_block(input int s);
        for (int a = 0; a < 256; a++) mem[a] = DATA_W'($urandom);
        for (int i = 0; i < Z; i++) begin
            logical[i] = DATA_W'($urandom);
            mem[phys(i, s)] = logical[i];
        end
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, 32'({bus.ram_rd_en, bus.ram_rd_addr, bus.out_valid, bus.out_data,
                        bus.out_idx, bus.out_last, bus.busy, bus.done, bus.shift_err}), 32'd0);
    endtask

    // Runs one block: shift s, out_ready duty in percent, optional re-start
    // pulse at cycle restart_at, optional reset when idx reset_idx is shown.
    task automatic run_block(input int s, input int duty, input int restart_at, input int reset_idx);
        int   cyc, issued, accepted, first_vld, done_cyc;
        bit   fin, stall_prev;
        logic [DATA_W-1:0] pd;
        logic [ADDR_W-1:0] pi;
        cyc = 0; issued = 0; accepted = 0; first_vld = -1; done_cyc = -1;
        fin = 1'b0; stall_prev = 1'b0; pd = '0; pi = '0;
        load_block(s);
        @(negedge clk);
        bus.start       = 1'b1;
        bus.cyclic_shif = SHIFT_W'(s);
        bus.out_ready   = 1'b1;
        while (!fin && cyc < 3000) begin
            @(negedge clk);
            bus.start       = (restart_at >= 0 && cyc == restart_at);
            bus.cyclic_shif = SHIFT_W'(70);
            bus.out_ready   = ($urandom_range(99) < duty);
            #1;
            if (cyc == 0) check("busy_after_start", 32'(bus.busy), 32'd1);
            if (reset_idx >= 0 && bus.out_valid && accepted == reset_idx) begin
                rst_n = 1'b0;
                #1;
                check_all_zero("outputs_in_reset");
                fin = 1'b1;
            end else begin
                check("no_shift_err_busy", 32'(bus.shift_err), 32'd0);
                check("outstanding_le2", 32'((issued - accepted) <= 2), 32'd1);
                if (stall_prev) begin
                    check("stall_valid", 32'(bus.out_valid), 32'd1);
                    check("stall_data", 32'(bus.out_data), 32'(pd));
                    check("stall_idx", 32'(bus.out_idx), 32'(pi));
                end
                if (bus.ram_rd_en) begin
                    check("rd_addr", 32'(bus.ram_rd_addr), 32'(phys(issued, s)));
                    issued++;
                end
                if (bus.out_valid && first_vld < 0) first_vld = cyc;
                if (bus.out_valid && bus.out_ready) begin
                    check("out_idx", 32'(bus.out_idx), 32'(accepted));
                    check("out_data", 32'(bus.out_data), 32'(logical[accepted % Z]));
                    check("out_last", 32'(bus.out_last), 32'(accepted == Z - 1));
                    accepted++;
                end
                stall_prev = bus.out_valid && !bus.out_ready;
                pd = bus.out_data;
                pi = bus.out_idx;
                if (bus.done) begin
                    check("done_after_last", 32'(accepted), 32'(Z));
                    check("busy_clear_at_done", 32'(bus.busy), 32'd0);
                    done_cyc = cyc;
                    fin = 1'b1;
                end
                cyc++;
            end
        end
        if (reset_idx < 0) begin
            check("done_seen", 32'(fin), 32'd1);
            check("reads_total", 32'(issued), 32'(Z));
            check("accepted_total", 32'(accepted), 32'(Z));
            if (duty == 100) begin
                check("first_valid_cycle", 32'(first_vld), 32'd2);
                check("done_cycle", 32'(done_cyc), 32'(Z + 2));
            end
            bus.out_ready = 1'b1;
            repeat (4) begin
                @(negedge clk);
                bus.start = 1'b0;
                #1;
                check("single_done", 32'(bus.done), 32'd0);
                check("idle_busy", 32'(bus.busy), 32'd0);
                check("idle_no_read", 32'(bus.ram_rd_en), 32'd0);
                check("idle_no_valid", 32'(bus.out_valid), 32'd0);
            end
        end
    endtask

    task automatic bad_shift(input int s);
        @(negedge clk);
        bus.start       = 1'b1;
        bus.cyclic_shif = SHIFT_W'(s);
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        check("shift_err_pulse", 32'(bus.shift_err), 32'd1);
        check("shift_err_busy", 32'(bus.busy), 32'd0);
        check("shift_err_no_read", 32'(bus.ram_rd_en), 32'd0);
        repeat (3) begin
            @(negedge clk);
            #1;
            check("shift_err_one_cycle", 32'(bus.shift_err), 32'd0);
            check("shift_err_still_idle", 32'({bus.busy, bus.ram_rd_en}), 32'd0);
        end
    endtask

    initial begin
        bus.start       = 1'b0;
        bus.cyclic_shif = '0;
        bus.out_ready   = 1'b0;
        rst_n           = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset_state");
        rst_n = 1'b1;

        run_block(0, 100, -1, -1);
        run_block(5, 100, -1, -1);
        run_block(64, 100, -1, -1);
        bad_shift(70);
        bad_shift(65);
        run_block(17, 30, -1, -1);
        run_block($urandom_range(0, 63), 60, -1, -1);

        // Reset mid-block, then a clean block must follow.
        run_block(9, 100, -1, 20);
        repeat (2) begin
            @(negedge clk);
            #1;
            check_all_zero("reset_hold");
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            check_all_zero("after_reset_no_done");
        end
        run_block(3, 100, -1, -1);

        // Second start during READ must be ignored.
        run_block(33, 100, 10, -1);
        run_block(62, 50, 5, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
